out_fifo_buffer: RTL
====================

OUT_FIFO_BUFFER -- requirements
Module: out_fifo_buffer

Interface
REQ-001 SHALL have parameter DataWidth, default 32, word width in bits.
REQ-002 SHALL have parameter BufferWidth, default 2, address width; depth BufferSize = 2**BufferWidth.
REQ-003 SHALL have parameter AlmostFullLevel, default 3, occupancy at or above which AlmostFull asserts (1..BufferSize).
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port Push  input  1  write DataIn at tail.
REQ-007 SHALL have port Pop  input  1  retire head word.
REQ-008 SHALL have port Flush  input  1  synchronous discard of all contents.
REQ-009 SHALL have port DataIn  input  DataWidth  write data.
REQ-010 SHALL have port DataOut  output  DataWidth  head word, first-word-fall-through.
REQ-011 SHALL have port Full  output  1  occupancy == BufferSize.
REQ-012 SHALL have port Empty  output  1  occupancy == 0.
REQ-013 SHALL have port AlmostFull  output  1  occupancy >= AlmostFullLevel.
REQ-014 SHALL have port Count  output  BufferWidth+1  current occupancy.
REQ-015 SHALL have port ReadyM  output  BufferSize  per-slot valid mask.
REQ-016 SHALL have port Overflow  output  1  sticky: push refused while full.
REQ-017 SHALL have port Underflow  output  1  sticky: pop refused while empty.

Function
REQ-018 SHALL keep write and read pointers of BufferWidth+1 bits each; low bits address storage, MSB is wrap (round) bit.
REQ-019 SHALL derive Count = W_Ptr - R_Ptr modulo 2**(BufferWidth+1); Full when addresses equal and wrap bits differ; Empty when pointers equal.
REQ-020 SHALL drive DataOut combinationally from storage[R_Ptr low bits]; value undefined-but-stable when Empty (last slot content).
REQ-021 SHALL accept Push when not Full, or when Full and Pop asserted in the same cycle; accepted push writes DataIn and increments W_Ptr.
REQ-022 SHALL accept Pop when not Empty; accepted pop increments R_Ptr; pop with push on Empty is refused (no bypass), push still accepted.
REQ-023 SHALL on Full with Push and Pop both asserted retire head and write DataIn into the freed slot; Count stays BufferSize.
REQ-024 SHALL ignore refused Push (no write, no pointer move) and set Overflow; ignore refused Pop and set Underflow.
REQ-025 SHALL on Flush (priority over Push/Pop) set both pointers to 0 and clear Overflow/Underflow next edge; storage not cleared.
REQ-026 SHALL set ReadyM[i] = 1 iff slot i lies in [R_Ptr, W_Ptr) modulo BufferSize, handling wrap; all ones when Full, all zeros when Empty.
REQ-027 SHALL update Full, Empty, AlmostFull, Count, ReadyM combinationally from registered pointers (valid the cycle after the accepting edge).
REQ-028 SHALL work for any BufferWidth >= 1; no hardcoded slot indices.

Reset
REQ-029 SHALL on rst asynchronously clear pointers, storage, Overflow, Underflow.
REQ-030 SHALL present after reset: Count=0, Empty=1, Full=0, AlmostFull=0, ReadyM=0, DataOut=0, Overflow=0, Underflow=0.
REQ-031 SHALL on rst asserted mid-operation discard all contents immediately, regardless of Push/Pop/Flush.

Structure
REQ-032 SHALL place default DataWidth/BufferWidth constants in shared package fifo_pkg.
REQ-033 SHALL implement each pointer as one sub-module fifo_ptr (BufferWidth+1-bit wrapping counter with enable, async clear, sync clear), instantiated twice.
REQ-034 SHALL hold storage as a register array inside out_fifo_buffer.

Verification (DataWidth=32, BufferWidth=2, AlmostFullLevel=3)
REQ-035 SHALL test: reset, push 0xA0..0xA3 -> Count 1,2,3,4; AlmostFull at 3; Full and ReadyM=4'b1111 at 4; DataOut=0xA0.
REQ-036 SHALL test: from Full push 0xA4 alone -> refused, Overflow=1, Count=4; then Push+Pop with 0xB0 -> DataOut=0xA1, Count=4, 0xB0 read last.
REQ-037 SHALL test: wrap-around: push/pop 6 words singly -> pointers wrap, ReadyM tracks e.g. 4'b1001 with head slot 3, tail slot 1; FWFT order preserved.
REQ-038 SHALL test: Pop on Empty (with and without Push 0xC0) -> Underflow=1, Count 0 resp. 1, DataOut=0xC0 in second case.
REQ-039 SHALL test: Flush with Push asserted at Count=3 -> Count=0, Empty=1, flags cleared, pushed word dropped.
REQ-040 SHALL test: rst pulse between clock edges at Count=2 -> outputs at reset values before next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the output FIFO: default word width and address width.
package fifo_pkg;

  localparam int unsigned DefaultDataWidth   = 32;
  localparam int unsigned DefaultBufferWidth = 2;

endpackage : fifo_pkg

// File: rtl/fifo_ptr.sv
// Wrapping pointer for the output FIFO: Width-bit counter whose MSB is the
// round bit. Async clear on rst, sync clear on clr_i, increment on en_i.
module fifo_ptr #(
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] ptr_o
);

  logic [Width-1:0] ptr_q;
  logic [Width-1:0] ptr_d;

  // Next pointer: sync clear wins over increment; natural wrap at 2**Width.
  always_comb begin
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = ptr_q + Width'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule : fifo_ptr

// File: rtl/out_fifo_buffer.sv
// First-word-fall-through output FIFO with sticky overflow/underflow flags,
// occupancy count and a per-slot valid mask derived from the pointers.
module out_fifo_buffer
  import fifo_pkg::*;
#(
  parameter int unsigned DataWidth       = DefaultDataWidth,
  parameter int unsigned BufferWidth     = DefaultBufferWidth,
  parameter int unsigned AlmostFullLevel = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Push,
  input  logic                   Pop,
  input  logic                   Flush,
  input  logic [DataWidth-1:0]   DataIn,
  output logic [DataWidth-1:0]   DataOut,
  output logic                   Full,
  output logic                   Empty,
  output logic                   AlmostFull,
  output logic [BufferWidth:0]   Count,
  output logic [(2**BufferWidth)-1:0] ReadyM,
  output logic                   Overflow,
  output logic                   Underflow
);

  localparam int unsigned BufferSize = 2 ** BufferWidth;

  logic [DataWidth-1:0]   storage_q [BufferSize];
  logic [BufferWidth:0]   w_ptr_s;
  logic [BufferWidth:0]   r_ptr_s;
  logic [BufferWidth-1:0] w_addr_s;
  logic [BufferWidth-1:0] r_addr_s;
  logic [BufferWidth:0]   count_s;
  logic                   full_s;
  logic                   empty_s;
  logic                   push_ok_s;
  logic                   pop_ok_s;
  logic                   wr_en_s;
  logic                   rd_en_s;
  logic                   overflow_q;
  logic                   overflow_d;
  logic                   underflow_q;
  logic                   underflow_d;
  logic [BufferSize-1:0]  ready_s;

  assign w_addr_s = w_ptr_s[BufferWidth-1:0];
  assign r_addr_s = r_ptr_s[BufferWidth-1:0];
  assign count_s  = w_ptr_s - r_ptr_s;
  assign empty_s  = (w_ptr_s == r_ptr_s);
  assign full_s   = (w_addr_s == r_addr_s) && (w_ptr_s[BufferWidth] != r_ptr_s[BufferWidth]);

  // Acceptance: a full FIFO still takes a push when the head retires in the
  // same cycle; pop never bypasses into an empty FIFO. Flush suppresses both.
  always_comb begin
    push_ok_s = Push && (!full_s || Pop);
    pop_ok_s  = Pop && !empty_s;
    if (Flush) begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
    end else begin
      wr_en_s = push_ok_s;
      rd_en_s = pop_ok_s;
    end
  end

  fifo_ptr #(.Width(BufferWidth + 1)) u_w_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (Flush),
    .en_i  (wr_en_s),
    .ptr_o (w_ptr_s)
  );

  fifo_ptr #(.Width(BufferWidth + 1)) u_r_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (Flush),
    .en_i  (rd_en_s),
    .ptr_o (r_ptr_s)
  );

  // Storage array: cleared by reset only, written at the tail on accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BufferSize; i++) begin
        storage_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      storage_q[w_addr_s] <= DataIn;
    end
  end

  // Sticky error flags: set on refused requests, cleared by flush.
  always_comb begin
    if (Flush) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      overflow_d  = overflow_q  | (Push && !push_ok_s);
      underflow_d = underflow_q | (Pop && !pop_ok_s);
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Valid mask: slot i is live when its distance from the head is below Count.
  always_comb begin
    logic [BufferWidth-1:0] ofs;
    ofs     = '0;
    ready_s = '0;
    for (int i = 0; i < BufferSize; i++) begin
      ofs        = BufferWidth'(i) - r_addr_s;
      ready_s[i] = ({1'b0, ofs} < count_s);
    end
  end

  assign DataOut    = storage_q[r_addr_s];
  assign Full       = full_s;
  assign Empty      = empty_s;
  assign AlmostFull = (count_s >= (BufferWidth + 1)'(AlmostFullLevel));
  assign Count      = count_s;
  assign ReadyM     = ready_s;
  assign Overflow   = overflow_q;
  assign Underflow  = underflow_q;

endmodule : out_fifo_buffer
